// File: rtl/vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_fetch
//  Description : Framebuffer read stage for the VGA timing generator. Walks a
//                linear 16-bit-per-pixel framebuffer from a base address,
//                prefetches words through a small FIFO and replicates every
//                word horizontally and every line vertically by 2^pixel_width.
//                A frame restarts on each rising edge of the v-sync window.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_fetch #(
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [10:0]           screen_width,
    input  logic [10:0]           screen_height,
    input  logic [2:0]            pixel_width,
    input  logic                  v_sync_en,
    input  logic                  pixel_advance,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [15:0]           mem_data_in,
    output logic [15:0]           pixel_data,
    output logic                  pixel_valid,
    output logic                  underflow
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // Frame-start detection
    logic                  r_vs;
    logic                  r_vs_prev;
    logic                  w_frame_start;

    // Fetch-side walker
    logic [2:0]            r_pw;
    logic [ADDR_WIDTH-1:0] r_line_start;
    logic [ADDR_WIDTH-1:0] r_fetch_addr;
    logic [10:0]           r_fetch_x;
    logic [10:0]           r_fetch_line;
    logic [7:0]            r_vrep;
    logic [10:0]           w_lw;
    logic [10:0]           w_lw_last;
    logic [ADDR_WIDTH-1:0] w_next_line_start;
    logic [7:0]            w_rep_max;
    logic                  w_line_end;
    logic                  w_frame_end;
    logic                  w_issue;

    // Outstanding-read tracking
    logic                  r_inflight;
    logic                  r_discard;

    // Prefetch FIFO
    logic [15:0]           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_occupancy;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    // Consumer side
    logic [7:0]            r_crep;
    logic                  r_underflow;

    // ------------------------------------------------------------------------
    // Derived geometry and handshake terms
    // ------------------------------------------------------------------------
    // Logical width is the number of framebuffer words behind one displayed line.
    assign w_lw              = screen_width >> r_pw;
    assign w_lw_last         = w_lw - 11'd1;
    assign w_rep_max         = (8'd1 << r_pw) - 8'd1;
    assign w_next_line_start = r_line_start + ADDR_WIDTH'(w_lw);
    assign w_line_end        = (r_fetch_x == w_lw_last);
    assign w_frame_end       = w_line_end && (r_fetch_line == (screen_height - 11'd1));

    assign w_frame_start     = r_vs & ~r_vs_prev;

    // A request still on its way counts against the FIFO space it will need.
    assign w_occupancy       = r_count + CNT_W'(r_inflight);
    assign w_empty           = (r_count == '0);

    // Flush on frame start takes priority over any push or pop that cycle.
    assign w_push            = r_inflight & ~r_discard & ~w_frame_start;
    assign w_pop             = pixel_advance & ~w_empty & (r_crep == w_rep_max)
                               & ~w_frame_start;

    assign mem_read_en       = w_issue;
    assign mem_addr          = r_fetch_addr;
    assign pixel_valid       = ~w_empty;
    assign pixel_data        = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
    assign underflow         = r_underflow;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and read-request decode.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        if ((r_state == S_FETCH) && (w_occupancy < C_DEPTH)) begin
            w_issue = 1'b1;
        end
        if (w_frame_start) begin
            w_state_nxt = S_FETCH;
        end else if (w_issue && w_frame_end) begin
            w_state_nxt = S_DONE;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // Delay line on v_sync_en for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs      <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs      <= v_sync_en;
            r_vs_prev <= r_vs;
        end
    end

    // Fetch address walker: steps through a line, re-reads it for each
    // vertical repeat, then moves line_start on by one logical line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pw         <= 3'd0;
            r_line_start <= '0;
            r_fetch_addr <= '0;
            r_fetch_x    <= 11'd0;
            r_fetch_line <= 11'd0;
            r_vrep       <= 8'd0;
        end else if (w_frame_start) begin
            r_pw         <= pixel_width;
            r_line_start <= base_addr;
            r_fetch_addr <= base_addr;
            r_fetch_x    <= 11'd0;
            r_fetch_line <= 11'd0;
            r_vrep       <= 8'd0;
        end else if (w_issue) begin
            if (w_line_end) begin
                r_fetch_x    <= 11'd0;
                r_fetch_line <= r_fetch_line + 11'd1;
                if (r_vrep == w_rep_max) begin
                    r_vrep       <= 8'd0;
                    r_line_start <= w_next_line_start;
                    r_fetch_addr <= w_next_line_start;
                end else begin
                    r_vrep       <= r_vrep + 8'd1;
                    r_fetch_addr <= r_line_start;
                end
            end else begin
                r_fetch_x    <= r_fetch_x + 11'd1;
                r_fetch_addr <= r_fetch_addr + 1'b1;
            end
        end
    end

    // In-flight flag marks that mem_data_in is valid this cycle; the discard
    // flag kills a response whose request straddled a frame restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_discard  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_frame_start) begin
                r_discard <= w_issue;
            end else if (r_inflight) begin
                r_discard <= 1'b0;
            end
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= mem_data_in;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || w_frame_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Horizontal replication counter and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crep      <= 8'd0;
            r_underflow <= 1'b0;
        end else begin
            if (pixel_advance && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_frame_start) begin
                r_crep <= 8'd0;
            end else if (pixel_advance && !w_empty) begin
                r_crep <= (r_crep == w_rep_max) ? 8'd0 : r_crep + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pixel_fetch
//  Description : Directed self-checking bench for vga_pixel_fetch. The memory
//                model returns the requested address as data one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] base_addr;
    logic [10:0] screen_width;
    logic [10:0] screen_height;
    logic [2:0]  pixel_width;
    logic        v_sync_en;
    logic        pixel_advance;
    logic        mem_read_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in = 16'h0000;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        underflow;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] addr_q[$];

    vga_pixel_fetch #(
        .ADDR_WIDTH (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .base_addr     (base_addr),
        .screen_width  (screen_width),
        .screen_height (screen_height),
        .pixel_width   (pixel_width),
        .v_sync_en     (v_sync_en),
        .pixel_advance (pixel_advance),
        .mem_read_en   (mem_read_en),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .pixel_data    (pixel_data),
        .pixel_valid   (pixel_valid),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    // Memory model (data = address, one-cycle latency) and request log.
    always @(posedge clk) begin
        mem_data_in <= mem_read_en ? mem_addr : 16'hDEAD;
        if (mem_read_en) begin
            addr_q.push_back(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Raise v_sync_en in cycle N; returns at the negedge of cycle N+2 with the
    // request log cleared so it holds only reads of the new frame.
    task automatic start_frame(input logic [15:0] b, input logic [2:0] p,
                               input logic [10:0] w, input logic [10:0] h);
        base_addr     = b;
        pixel_width   = p;
        screen_width  = w;
        screen_height = h;
        v_sync_en     = 1'b1;
        @(negedge clk);
        v_sync_en     = 1'b0;
        @(negedge clk);
        addr_q.delete();
    endtask

    // Expected word address for word index i at pw=2, LW=320, base 0x1000.
    function automatic logic [15:0] rep2_addr(input int i);
        int line;
        line = i / 320;
        return 16'h1000 + 16'(((line / 4) * 320) + (i % 320));
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          k;
        int          errs;
        int          aerrs;
        int          cyc;
        logic [15:0] v1279;
        logic [15:0] v1280;
        logic [15:0] expd;
        logic [15:0] tmp;

        reset         = 1'b1;
        base_addr     = 16'h0000;
        screen_width  = 11'd1280;
        screen_height = 11'd960;
        pixel_width   = 3'd0;
        v_sync_en     = 1'b0;
        pixel_advance = 1'b0;

        // ---- reset and idle ----
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_read_en", mem_read_en, 0);
        check("rst_valid",   pixel_valid, 0);
        check("rst_data",    pixel_data,  0);
        check("rst_uflow",   underflow,   0);
        check("rst_addr",    mem_addr,    0);
        repeat (5) @(negedge clk);
        check("idle_no_reads", addr_q.size(), 0);

        // ---- frame start latency, pw=0, base 0x1000 ----
        base_addr     = 16'h1000;
        screen_width  = 11'd1280;
        screen_height = 11'd960;
        pixel_width   = 3'd0;
        v_sync_en     = 1'b1;                       // cycle N
        @(negedge clk);                             // N+1
        v_sync_en = 1'b0;
        check("fs_n1_read_en", mem_read_en, 0);
        @(negedge clk);                             // N+2
        check("fs_n2_read_en", mem_read_en, 1);
        check("fs_n2_addr",    mem_addr,    16'h1000);
        @(negedge clk);                             // N+3
        check("fs_n3_valid",   pixel_valid, 0);
        @(negedge clk);                             // N+4
        check("fs_n4_valid",   pixel_valid, 1);
        check("fs_n4_data",    pixel_data,  16'h1000);

        // ---- backpressure ----
        repeat (8) @(negedge clk);
        check("bp_reads",   addr_q.size(), 4);
        check("bp_read_en", mem_read_en,   0);
        check("bp_hold",    pixel_data,    16'h1000);
        pixel_advance = 1'b1;
        @(negedge clk);
        pixel_advance = 1'b0;
        check("bp_pop_data", pixel_data, 16'h1001);
        repeat (4) @(negedge clk);
        check("bp_one_more", addr_q.size(), 5);
        check("bp_idle_en",  mem_read_en,   0);
        tmp = (addr_q.size() > 4) ? addr_q[4] : 16'h0000;
        check("bp_fifth_addr", tmp, 16'h1004);

        // ---- pw=0 continuous streaming across a line boundary ----
        errs  = 0;
        v1279 = 16'h0000;
        v1280 = 16'h0000;
        pixel_advance = 1'b1;
        for (k = 1; k < 2600; k++) begin
            expd = 16'h1000 + 16'(k);
            if (!pixel_valid || pixel_data !== expd) errs++;
            if (k == 1279) v1279 = pixel_data;
            if (k == 1280) v1280 = pixel_data;
            @(negedge clk);
        end
        pixel_advance = 1'b0;
        check("pw0_seq_errs",  errs,      0);
        check("pw0_line0_end", v1279,     16'h14FF);
        check("pw0_line1_beg", v1280,     16'h1500);
        check("pw0_no_uflow",  underflow, 0);

        // ---- frame end with address wrap: base 0xFF00, 1280x2 ----
        start_frame(16'hFF00, 3'd0, 11'd1280, 11'd2);
        k = 0; errs = 0; cyc = 0;
        while (k < 2560 && cyc < 6000) begin
            if (pixel_valid) begin
                expd = 16'hFF00 + 16'(k);
                if (pixel_data !== expd) errs++;
                pixel_advance = 1'b1;
                k++;
            end else begin
                pixel_advance = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        pixel_advance = 1'b0;
        repeat (5) @(negedge clk);
        aerrs = 0;
        foreach (addr_q[i]) begin
            if (addr_q[i] !== 16'hFF00 + 16'(i)) aerrs++;
        end
        check("end_pops",      k,             2560);
        check("end_data_errs", errs,          0);
        check("end_reads",     addr_q.size(), 2560);
        check("end_addr_errs", aerrs,         0);
        tmp = (addr_q.size() > 2559) ? addr_q[2559] : 16'h0000;
        check("end_last_addr", tmp,           16'h08FF);
        check("end_read_en",   mem_read_en,   0);
        check("end_valid",     pixel_valid,   0);
        check("end_uflow",     underflow,     0);

        // ---- pw=2 replication, 1280 wide (LW=320) ----
        start_frame(16'h1000, 3'd2, 11'd1280, 11'd960);
        k = 0; errs = 0; cyc = 0;
        while (k < 6400 && cyc < 12000) begin
            if (pixel_valid) begin
                if (pixel_data !== rep2_addr(k / 4)) errs++;
                pixel_advance = 1'b1;
                k++;
            end else begin
                pixel_advance = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        pixel_advance = 1'b0;
        aerrs = 0;
        foreach (addr_q[i]) begin
            if (addr_q[i] !== rep2_addr(i)) aerrs++;
        end
        check("pw2_advances",  k,    6400);
        check("pw2_data_errs", errs, 0);
        check("pw2_addr_errs", aerrs, 0);
        tmp = (addr_q.size() > 960) ? addr_q[960] : 16'h0000;
        check("pw2_line3_start", tmp, 16'h1000);
        tmp = (addr_q.size() > 1279) ? addr_q[1279] : 16'h0000;
        check("pw2_line3_end", tmp, 16'h113F);
        tmp = (addr_q.size() > 1280) ? addr_q[1280] : 16'h0000;
        check("pw2_line4_start", tmp, 16'h1140);

        // ---- restart while a read is in flight ----
        base_addr     = 16'h2000;
        pixel_width   = 3'd0;
        screen_width  = 11'd1280;
        screen_height = 11'd960;
        v_sync_en     = 1'b1;                       // N
        @(negedge clk);                             // N+1
        v_sync_en = 1'b0;
        @(negedge clk);                             // N+2
        check("mid_n2_addr", mem_addr, 16'h2000);
        base_addr = 16'h3000;
        v_sync_en = 1'b1;
        @(negedge clk);                             // N+3: restart, read in flight
        v_sync_en = 1'b0;
        check("mid_n3_read_en", mem_read_en, 1);
        check("mid_n3_addr",    mem_addr,    16'h2001);
        @(negedge clk);                             // N+4
        check("mid_n4_valid", pixel_valid, 0);
        check("mid_n4_addr",  mem_addr,    16'h3000);
        @(negedge clk);                             // N+5
        check("mid_n5_dropped", pixel_valid, 0);
        @(negedge clk);                             // N+6
        check("mid_n6_valid", pixel_valid, 1);
        check("mid_n6_data",  pixel_data,  16'h3000);

        // ---- underflow is sticky across frame start ----
        start_frame(16'h1000, 3'd0, 11'd1280, 11'd960);
        check("uf_pre", underflow, 0);
        pixel_advance = 1'b1;
        @(negedge clk);
        pixel_advance = 1'b0;
        check("uf_set",   underflow,   1);
        check("uf_valid", pixel_valid, 0);
        start_frame(16'h1000, 3'd0, 11'd1280, 11'd960);
        repeat (3) @(negedge clk);
        check("uf_sticky",     underflow,   1);
        check("uf_refill",     pixel_valid, 1);
        check("uf_refill_dat", pixel_data,  16'h1000);

        // ---- reset mid-frame ----
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_uflow",   underflow,   0);
        check("rst2_valid",   pixel_valid, 0);
        check("rst2_read_en", mem_read_en, 0);
        repeat (3) @(negedge clk);
        check("rst2_ignore_resp", pixel_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Framebuffer read stage that sits directly upstream of the `vga` timing generator and supplies its `pixel_in`. It walks a linear 16-bit-per-pixel framebuffer from a base address, prefetches words through a small FIFO, and replicates each word horizontally and each line vertically by 2^`pixel_width`. This implements the `resolution` scaling the timing generator advertises. Frames are restarted on the timing generator's vertical-sync window.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, framebuffer word-address width
- `FIFO_DEPTH`, 4, prefetch FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  pixel clock (same clock as the timing generator)
- `reset`  in  1  synchronous, active-high; one clock, sampled on rising edge of `clk`
- `base_addr`  in  ADDR_WIDTH  framebuffer start word address; sampled at frame start
- `screen_width`  in  11  active pixels per line (1920 or 1280)
- `screen_height`  in  11  active lines per frame (1080 or 960)
- `pixel_width`  in  3  replication shift, 0..3; sampled at frame start
- `v_sync_en`  in  1  high during vertical sync window
- `pixel_advance`  in  1  consume one displayed pixel this cycle
- `mem_read_en`  out  1  framebuffer read request
- `mem_addr`  out  ADDR_WIDTH  read address, valid with `mem_read_en`
- `mem_data_in`  in  16  read data, valid exactly 1 cycle after request
- `pixel_data`  out  16  current pixel (RGB565); 0 when FIFO empty
- `pixel_valid`  out  1  FIFO non-empty
- `underflow`  out  1  sticky: advance attempted while empty

## Operation
- Reset: state IDLE, FIFO empty, all counters 0, `mem_read_en`=0, `mem_addr`=0, `pixel_data`=0, `pixel_valid`=0, `underflow`=0, in-flight flag 0.
- States: IDLE → (frame start) → FETCH → (last word of last line issued) → DONE → (frame start) → FETCH. A frame start in any state, including FETCH, restarts the frame.
- Frame start: `v_sync_en` registered each cycle. A rising edge (current 1, previous 0) triggers the following:
  - latch `base_addr` and `pixel_width`
  - line_start = fetch address = base_addr
  - fetch x = 0, fetch line = 0, vertical rep = 0
  - consumer rep = 0
  - flush the FIFO
  - set discard flag if a read is in flight
- Logical width LW = `screen_width` >> `pixel_width` (11-bit, truncating). The fetch side issues LW reads per displayed line, for `screen_height` displayed lines.
- Line end (fetch x reaches LW−1 and issues):
  - vertical rep increments
  - if it wraps at 2^pw, line_start += LW and rep = 0; the next line fetches from the new line_start
  - otherwise the same line_start is re-fetched
- Addresses wrap modulo 2^ADDR_WIDTH.
- Issue rule: `mem_read_en`=1 when state=FETCH and (FIFO count + in-flight) < FIFO_DEPTH. At most one request per cycle.
- Response: written to FIFO the cycle it is valid, unless the discard flag is set. In that case it is dropped and the flag cleared.
- Consumer: `pixel_data`/`pixel_valid` are show-ahead from the FIFO head.
  - each `pixel_advance` with FIFO non-empty increments consumer rep
  - when rep = 2^pw − 1, the head is popped and rep = 0
- Underflow: `pixel_advance` with FIFO empty sets `underflow` (cleared only by `reset`) and changes no other state.
- Simultaneous push and pop in one cycle: count unchanged. Frame start in the same cycle as push/pop: flush wins.

## Timing
- Request-to-FIFO latency: request at cycle N, data valid N+1, written end of N+1, `pixel_valid` high at N+2.
- Frame-start latency: `v_sync_en` first high at cycle N → flush at end of N+1 → first `mem_read_en` in cycle N+2 → `pixel_valid` at N+4.
- Throughput: steady state sustains one word per cycle (pw=0) once the FIFO is primed.
- `pixel_data` changes only on a pop, flush, push into an empty FIFO, or reset.
- `reset` mid-frame: returns to IDLE next cycle. Outstanding responses arriving after reset are ignored.

## Test plan
- Reset then idle: `reset` 1 for 2 cycles → `mem_read_en`=0, `pixel_valid`=0, `pixel_data`=0, `underflow`=0; no reads until a `v_sync_en` rise.
- pw=0 sequencing: `base_addr`=0x1000, width 1280, height 960, memory returns data=address, continuous `pixel_advance` after priming → `pixel_data` sequence 0x1000…0x14FF on line 0, 0x1500 starts line 1; last word of frame is 0x1000+1280·960−1 mod 2^16.
- pw=2 replication: width 1280 (LW=320) → each word held for 4 advances; addresses 0x1000..0x113F are fetched four times (lines 0–3) before 0x1140.
- Backpressure: `pixel_advance` held 0 → exactly FIFO_DEPTH reads issued, then `mem_read_en` stays 0; one advance at pw=0 → exactly one further read.
- Mid-frame vsync: raise `v_sync_en` while a read is in flight → that response is dropped, FIFO empty; next fetched address = `base_addr`.
- Underflow: `pixel_advance` before priming completes → `underflow`=1 and it remains 1 through the next frame start; cleared only by `reset`.
